// File: rtl/dap_shift_pkg.sv
// dap_shift_pkg: shared types, widths and length decode for the DAP bit shifter
package dap_shift_pkg;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;
  localparam int CNT_W  = 6;
  typedef enum logic [1:0] {IDLE, ARM, SHIFT, RESP} state_e;
  function automatic logic [CNT_W-1:0] len_decode(input logic [LEN_W-1:0] l);
    return (l == '0) ? CNT_W'(DATA_W) : CNT_W'(l);
  endfunction
endpackage

// File: rtl/dap_shift_align.sv
// dap_shift_align: right-justifies a MSB-entered capture word to its bit count
module dap_shift_align #(
  parameter int W = 32
) (
  input  logic [W-1:0] rx,
  input  logic [5:0]   len,
  output logic [W-1:0] data
);
  logic [5:0] sh;
  assign sh   = 6'(W) - len;
  assign data = rx >> sh;
endmodule

// File: rtl/dap_bit_shifter.sv
// dap_bit_shifter: serial engine driving one DAP pin per set pulse and capturing per sample pulse
module dap_bit_shifter #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              set_pulse,
  input  logic              sample_pulse,
  input  logic              abort,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_dir,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              io_out,
  output logic              io_oe,
  input  logic              io_in,
  output logic              clk_gate,
  output logic              busy
);
  import dap_shift_pkg::*;
  localparam int IW = $clog2(DATA_W);
  state_e state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, nset_q, nset_d, nsamp_q, nsamp_d, samp_inc;
  logic dir_q, dir_d, io_out_q, io_out_d, io_oe_q, io_oe_d, gate_q, gate_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rsp_q, rsp_d, rx_shift, aligned;
  assign rx_shift = DATA_W'({io_in, rx_q} >> 1);
  assign samp_inc = nsamp_q + 1'b1;
  dap_shift_align #(.W(DATA_W)) u_align (.rx(rx_shift), .len(len_q), .data(aligned));
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    dir_d    = dir_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    nset_d   = nset_q;
    nsamp_d  = nsamp_q;
    rsp_d    = rsp_q;
    io_out_d = io_out_q;
    io_oe_d  = io_oe_q;
    gate_d   = gate_q;
    if (abort) begin
      state_d = IDLE;
      io_oe_d = 1'b0;
      gate_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          len_d   = len_decode(cmd_len);
          dir_d   = cmd_dir;
          tx_d    = cmd_data;
          rx_d    = '0;
          nset_d  = '0;
          nsamp_d = '0;
          state_d = ARM;
        end
        ARM: if (set_pulse) begin
          io_out_d = tx_q[0];
          io_oe_d  = dir_q;
          gate_d   = 1'b1;
          nset_d   = CNT_W'(1);
          state_d  = SHIFT;
        end
        SHIFT: begin
          if (set_pulse && nset_q < len_q) begin
            io_out_d = tx_q[nset_q[IW-1:0]];
            nset_d   = nset_q + 1'b1;
          end
          if (sample_pulse) begin
            rx_d    = rx_shift;
            nsamp_d = samp_inc;
            if (samp_inc == len_q) begin
              rsp_d   = aligned;
              gate_d  = 1'b0;
              io_oe_d = 1'b0;
              state_d = RESP;
            end
          end
        end
        RESP: if (rsp_ready) state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      len_q    <= '0;
      dir_q    <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      nset_q   <= '0;
      nsamp_q  <= '0;
      rsp_q    <= '0;
      io_out_q <= 1'b0;
      io_oe_q  <= 1'b0;
      gate_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      dir_q    <= dir_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      nset_q   <= nset_d;
      nsamp_q  <= nsamp_d;
      rsp_q    <= rsp_d;
      io_out_q <= io_out_d;
      io_oe_q  <= io_oe_d;
      gate_q   <= gate_d;
    end
  end
  // abort blocks the handshake so a cancelled cycle never looks accepted
  assign cmd_ready = (state_q == IDLE) && !abort;
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign rsp_data  = rsp_q;
  assign io_out    = io_out_q;
  assign io_oe     = io_oe_q;
  assign clk_gate  = gate_q;
endmodule

// File: tb/tb_dap_bit_shifter.sv
// tb_dap_bit_shifter: randomized pulse/command stimulus checked every cycle against a transaction model
module tb_dap_bit_shifter;
  logic clk = 0, resetn = 0, set_pulse = 0, sample_pulse = 0, abort = 0;
  logic cmd_valid = 0, cmd_dir = 0, rsp_ready = 0, io_in = 0;
  logic [4:0] cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, io_out, io_oe, clk_gate, busy;
  logic [31:0] rsp_data;
  always #5 clk = ~clk;
  dap_bit_shifter dut (
    .clk(clk), .resetn(resetn), .set_pulse(set_pulse), .sample_pulse(sample_pulse),
    .abort(abort), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_dir(cmd_dir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .io_out(io_out), .io_oe(io_oe), .io_in(io_in),
    .clk_gate(clk_gate), .busy(busy)
  );
  int vectors = 0, miscompares = 0;
  int m_phase = 0, m_len = 0, m_sets = 0, m_samps = 0;
  logic m_dir = 0;
  logic [31:0] m_tx = '0, m_rx = '0, e_rsp = '0, pat = '0;
  logic e_out = 0, e_oe = 0, e_gate = 0;
  int per = 2, dly = 2, cnt = 0, io_mode = 0;
  logic [15:0] hist = '0;
  bit abort_en = 0, rec = 0;
  logic drv[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask
  always @(negedge clk) begin
    chk("io_out", 32'(io_out), 32'(e_out));
    chk("io_oe", 32'(io_oe), 32'(e_oe));
    chk("clk_gate", 32'(clk_gate), 32'(e_gate));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 3));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("cmd_ready", 32'(cmd_ready), 32'((m_phase == 0) && !abort));
    chk("rsp_data", rsp_data, e_rsp);
  end
  // Model: bits land in the response at the index of their counted sample
  task automatic model_update();
    int ps = m_sets;
    if (!resetn) begin
      m_phase = 0; e_out = 0; e_oe = 0; e_gate = 0; e_rsp = '0;
    end else if (abort) begin
      m_phase = 0; e_oe = 0; e_gate = 0;
    end else if (m_phase == 0) begin
      if (cmd_valid) begin
        m_len = (cmd_len == 0) ? 32 : int'(cmd_len);
        m_dir = cmd_dir; m_tx = cmd_data; m_sets = 0; m_samps = 0; m_rx = '0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (set_pulse) begin
        e_out = m_tx[0]; e_oe = m_dir; e_gate = 1; m_sets = 1; m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (sample_pulse) begin
        m_rx[m_samps] = io_in;
        m_samps++;
      end
      if (set_pulse && m_sets < m_len) begin
        e_out = m_tx[m_sets];
        m_sets++;
      end
      if (m_samps == m_len) begin
        e_rsp = m_rx; e_oe = 0; e_gate = 0; m_phase = 3;
      end
    end else if (rsp_ready) m_phase = 0;
    if (rec && m_sets > ps) drv.push_back(io_out);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    cnt = (cnt + 1) % per;
    set_pulse = (cnt == 0);
    hist = {hist[14:0], set_pulse};
    sample_pulse = hist[dly];
    io_in = (io_mode == 1) ? io_out : (io_mode == 2) ? pat[m_samps % 32] : 1'($urandom);
    abort = abort_en && ($urandom_range(0, 59) == 0);
  endtask
  task automatic run_cmd(input logic [4:0] l, input logic d, input logic [31:0] x,
                         input int hold, input bit offer, output logic [31:0] got);
    int n = 0;
    got = '0;
    cmd_len = l; cmd_dir = d; cmd_data = x; cmd_valid = 1;
    while (m_phase == 0 && n < 200) begin step(); n++; end
    if (n >= 200) fail_now("accept");
    cmd_valid = 0; cmd_data = $urandom; cmd_len = 5'($urandom);
    n = 0;
    while ((m_phase == 1 || m_phase == 2) && n < 5000) begin step(); n++; end
    if (n >= 5000) fail_now("complete");
    if (m_phase == 3) begin
      got = rsp_data;
      cmd_valid = offer;
      repeat (hold) step();
      if (offer) chk("rsp_hold", rsp_data, got);
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      cmd_valid = 0;
    end
  endtask
  initial begin
    logic [31:0] got;
    logic [7:0] a5_bits;
    int n;
    a5_bits = 8'b1010_0101;
    repeat (3) step();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_data", rsp_data, 32'd0);
    resetn = 1;
    step();
    per = 2; dly = 2; io_mode = 0; rec = 1; drv.delete();
    run_cmd(5'd8, 1'b1, 32'h0000_00A5, 0, 0, got);
    rec = 0;
    chk("a5_nbits", 32'(drv.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < drv.size()) chk("a5_bit", 32'(drv[i]), 32'(a5_bits[i]));
    io_mode = 2; pat = 32'b011;
    run_cmd(5'd3, 1'b0, 32'hFFFF_FFFF, 0, 0, got);
    chk("cap3", got, 32'h0000_0003);
    per = 4; dly = 3; io_mode = 1;
    run_cmd(5'd0, 1'b1, 32'hDEAD_BEEF, 1, 0, got);
    chk("loop32", got, 32'hDEAD_BEEF);
    per = 3; dly = 0; io_mode = 2; pat = '1;
    run_cmd(5'd4, 1'b1, 32'h0000_0005, 0, 0, got);
    chk("coincide", got, 32'h0000_000F);
    per = 2; dly = 1; io_mode = 0;
    cmd_len = 5'd16; cmd_dir = 1; cmd_data = $urandom; cmd_valid = 1;
    n = 0;
    while (m_phase == 0 && n < 50) begin step(); n++; end
    cmd_valid = 0;
    n = 0;
    while (m_samps < 5 && n < 200) begin step(); n++; end
    if (n >= 200) fail_now("abort_wait");
    abort = 1;
    step();
    chk("abort_oe", 32'(io_oe), 32'd0);
    chk("abort_gate", 32'(clk_gate), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (6) step();
    run_cmd(5'd16, 1'b1, 32'h1234_5678, 0, 0, got);
    chk("after_abort", got, e_rsp);
    run_cmd(5'd6, 1'b1, 32'h0000_002D, 10, 1, got);
    abort_en = 1;
    for (int k = 0; k < 60; k++) begin
      per = $urandom_range(2, 5);
      dly = $urandom_range(0, per);
      io_mode = $urandom_range(0, 1);
      run_cmd(5'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3), 0, got);
    end
    abort_en = 0;
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dap_bit_shifter.md
# dap_bit_shifter

Bit-level serial engine for the DAP controller, on the consuming side of the baud generator. It takes a word command (length, direction, data) over a valid/ready handshake. It drives data bits on each set pulse and captures `io_in` on each sample pulse. It then returns the captured word over a second valid/ready handshake. It runs in the baud generator's `sclk_in` domain, and its `clk_gate` qualifies `sclk_out` toward the GPIO.

## Interface
Parameters:
- `DATA_W`, 32, maximum bits per command
- `LEN_W`, 5, width of `cmd_len`; `cmd_len==0` means `DATA_W` bits

Ports:
- `clk`  in  1  same net as the baud generator's `sclk_in`
- `resetn`  in  1  asynchronous, active-low reset
- `set_pulse`  in  1  baud generator `sclk_pulse`; one-cycle drive strobe
- `sample_pulse`  in  1  baud generator `sclk_delay_pulse`; one-cycle capture strobe
- `abort`  in  1  synchronous cancel, any state
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high
- `cmd_len`  in  LEN_W  bit count, 1..31, or 0 for 32
- `cmd_dir`  in  1  1 = drive `cmd_data`; 0 = capture only, pin released
- `cmd_data`  in  DATA_W  transmit word, LSB first
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumed
- `rsp_data`  out  DATA_W  captured bits, right-justified, first bit at bit 0
- `io_out`  out  1  pin data
- `io_oe`  out  1  pin output enable
- `io_in`  in  1  pin input, already synchronised upstream
- `clk_gate`  out  1  enable for `sclk_out`
- `busy`  out  1  state is not IDLE

## Operation
- **Reset values:** state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `io_out`=0, `io_oe`=0, `clk_gate`=0, `busy`=0.
- **IDLE:** `cmd_ready`=1. On handshake:
  - latch `len`, where 0 maps to 32;
  - latch `dir` and `tx`;
  - clear `rx`, `nset` and `nsamp`;
  - go to ARM.
- **ARM:** wait for `set_pulse`. On the pulse:
  - `io_out`=tx[0], `io_oe`=dir, `clk_gate`=1, `nset`=1;
  - go to SHIFT.
  - A `sample_pulse` arriving in ARM is ignored.
- **SHIFT:**
  - On `sample_pulse`: `rx`={io_in, rx[DATA_W-1:1]}, `nsamp`+1.
  - On `set_pulse` with `nset`<`len`: `io_out`=tx[nset], `nset`+1.
  - If both pulses arrive in the same cycle, both actions apply. The sample takes the present `io_in`, and the new bit appears the next cycle.
  - When the `nsamp` increment reaches `len`:
    - `rsp_data`=rx_next >> (DATA_W-len), using a 6-bit shift amount;
    - `clk_gate`=0, `io_oe`=0; `io_out` holds its last value;
    - go to RESP.
- **RESP:** `rsp_valid`=1 with `rsp_data` stable until `rsp_ready`, then go to IDLE. Pulses arriving in RESP are ignored. No command is accepted until the response is consumed.
- **abort:** wins over every other event in the same cycle.
  - Next state IDLE; `io_oe`, `clk_gate` and `rsp_valid` go to 0.
  - No response is produced.
  - An abort in RESP discards the pending response.
- **Capture-only commands (`cmd_dir`=0):** `io_out` still updates but `io_oe` stays 0. Turnaround cycles are issued as capture commands and the caller discards their data.
- **Counters:** `nset` and `nsamp` are 6 bits and compare against `len`, range 1..32. They never wrap, because completion always happens at `len`.

## Timing
- Command handshake at edge N gives ARM at N+1. The first drive is applied on the clock after the first `set_pulse` seen in ARM.
- `rsp_valid` rises on the clock after the final counted `sample_pulse`. It falls on the clock after `rsp_ready` is sampled high.
- Back-to-back commands are possible. `cmd_ready` is high in the cycle after the response handshake.
- `abort` takes effect at the next edge.
- `busy` is registered from the state.
- The generator's `sclk_pulse` marks a cycle one `sclk_in` before an `sclk_out` rising edge. Each driven bit is therefore stable across one rising edge. With DELAY≥1, the sample falls after that bit's drive.

## Structure
- Package `dap_shift_pkg`:
  - state enum: IDLE, ARM, SHIFT, RESP;
  - `DATA_W`=32, `LEN_W`=5;
  - len decode function: 0→32.
- Optional sub-module `dap_shift_align`: combinational right-justify, `rx >> (DATA_W-len)`. Otherwise the block is a single module.

## Test plan
- Baud generator DIV=1, DELAY=2, command len=8, dir=1, data=0xA5 → `io_out` reads 1,0,1,0,0,1,0,1 on successive set pulses. `io_oe`=1 throughout, `rsp_valid` comes after the 8th sample, `io_oe`=0 in RESP.
- len=3, dir=0, `io_in` driven 1,1,0 at the samples → `io_oe` stays 0 and `rsp_data`=0x00000003.
- len=0, dir=1, data=0xDEADBEEF, `io_in` looped from `io_out`, DELAY=3 → `rsp_data`=0xDEADBEEF after exactly 32 samples.
- DELAY=0, so the pulses coincide; len=4, `io_in` constant 1 → the ARM sample is ignored and `rsp_data`=0xF after 4 SHIFT samples.
- `abort` asserted after 5 of 16 bits → IDLE on the next edge, `io_oe`=0, `clk_gate`=0. There is no `rsp_valid`, and the next command completes normally.
- `rsp_ready` held low for 10 cycles → `rsp_valid` and `rsp_data` stay stable, `cmd_ready` stays 0, and a `cmd_valid` offered meanwhile is not accepted.
